// File: rtl/qupls_irq_inject_pkg.sv
// Shared QUPLS definitions: the interrupt-injector state encoding, the CHK opcode and the pending test.
package QuplsPkg;

   typedef enum logic [1:0] {
      IRQ_IDLE     = 2'd0,
      IRQ_PRESENT  = 2'd1,
      IRQ_INFLIGHT = 2'd2
   } irq_inject_state_t;

   localparam logic [6:0] OP_CHK   = 7'h43;
   localparam logic [2:0] IRQ_NONE = 3'd0;

   // A level is serviceable only when non-zero and strictly above the mask.
   function automatic logic irq_pending(input logic [2:0] lvl, input logic [2:0] mask);
      return (lvl != IRQ_NONE) && (lvl > mask);
   endfunction

endpackage

// File: rtl/qupls_irq_inject_if.sv
// Bundle of the interrupt-injector request/response signals.
interface qupls_irq_inject_if;
   logic [2:0] irq;
   logic [7:0] vect;
   logic [2:0] im;
   logic       en;
   logic       flush;
   logic       ack;
   logic       hirq;
   logic [2:0] irq_lat;
   logic [7:0] vect_lat;
   logic       busy;

   modport master (
      output irq, vect, im, en, flush, ack,
      input  hirq, irq_lat, vect_lat, busy
   );

   modport slave (
      input  irq, vect, im, en, flush, ack,
      output hirq, irq_lat, vect_lat, busy
   );
endinterface

// File: rtl/qupls_irq_timer.sv
// In-flight watchdog: cleared on load, counts while enabled, flags when TIMEOUT cycles have elapsed.
module qupls_irq_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_count,
   output logic o_tc
);

   localparam int unsigned    W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [W-1:0]   LP_TC = W'(TIMEOUT - 1);

   logic [W-1:0] r_cnt;

   // Counter holds at terminal count so o_tc stays up until the FSM leaves INFLIGHT.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_count && (r_cnt != LP_TC)) begin
         r_cnt <= r_cnt + W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_tc = (r_cnt == LP_TC);

endmodule

// File: rtl/qupls_irq_inject.sv
// Interrupt injector: presents a CHK request to the extract stage and tracks it until commit acks it.
// Optional watchdog re-presentation is enabled by defining QUPLS_IRQ_TIMEOUT_EN.
module qupls_irq_inject
   import QuplsPkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] irq_i,
   input  logic [7:0] vect_i,
   input  logic [2:0] im,
   input  logic       en,
   input  logic       flush,
   input  logic       ack_i,
   output logic       hirq_o,
   output logic [2:0] irq_o,
   output logic [7:0] vect_o,
   output logic       busy
);

   irq_inject_state_t r_state;
   irq_inject_state_t w_state_nxt;

   logic       r_hirq;
   logic       r_busy;
   logic [2:0] r_irq;
   logic [7:0] r_vect;

   logic       w_pending;
   logic       w_tc;
   logic       w_latch;
   logic       w_hirq_nxt;
   logic       w_busy_nxt;
   logic [2:0] w_irq_nxt;
   logic [7:0] w_vect_nxt;

   assign w_pending = irq_pending(irq_i, im);

`ifdef QUPLS_IRQ_TIMEOUT_EN
   logic w_tmr_load;
   logic w_tmr_count;
   logic w_tmr_tc;

   assign w_tmr_load  = (r_state != IRQ_INFLIGHT) && (w_state_nxt == IRQ_INFLIGHT);
   assign w_tmr_count = (r_state == IRQ_INFLIGHT);
   assign w_tc        = w_tmr_tc && (r_state == IRQ_INFLIGHT);

   qupls_irq_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_tmr_load),
      .i_count (w_tmr_count),
      .o_tc    (w_tmr_tc)
   );
`else
   // No watchdog in this build: the terminal count never fires.
   assign w_tc = (TIMEOUT == 32'd0) & 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IRQ_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; en wins over a same-cycle preemption, ack wins over flush.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IRQ_IDLE: begin
            if (w_pending) begin
               w_state_nxt = IRQ_PRESENT;
            end else begin
               w_state_nxt = IRQ_IDLE;
            end
         end
         IRQ_PRESENT: begin
            if (en) begin
               w_state_nxt = IRQ_INFLIGHT;
            end else if (!w_pending) begin
               w_state_nxt = IRQ_IDLE;
            end else begin
               w_state_nxt = IRQ_PRESENT;
            end
         end
         IRQ_INFLIGHT: begin
            if (ack_i) begin
               w_state_nxt = IRQ_IDLE;
            end else if (flush || w_tc) begin
               w_state_nxt = IRQ_PRESENT;
            end else begin
               w_state_nxt = IRQ_INFLIGHT;
            end
         end
         default: begin
            w_state_nxt = IRQ_IDLE;
         end
      endcase
   end

   // Output logic: latch on capture or on a strictly higher level while still presenting.
   always_comb begin
      w_latch    = 1'b0;
      w_hirq_nxt = (w_state_nxt == IRQ_PRESENT);
      w_busy_nxt = (w_state_nxt != IRQ_IDLE);
      if ((r_state == IRQ_IDLE) && (w_state_nxt == IRQ_PRESENT)) begin
         w_latch = 1'b1;
      end else if ((r_state == IRQ_PRESENT) && (w_state_nxt == IRQ_PRESENT) && (irq_i > r_irq)) begin
         w_latch = 1'b1;
      end else begin
         w_latch = 1'b0;
      end
      if (w_latch) begin
         w_irq_nxt  = irq_i;
         w_vect_nxt = vect_i;
      end else begin
         w_irq_nxt  = r_irq;
         w_vect_nxt = r_vect;
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hirq <= 1'b0;
         r_busy <= 1'b0;
         r_irq  <= 3'd0;
         r_vect <= 8'd0;
      end else begin
         r_hirq <= w_hirq_nxt;
         r_busy <= w_busy_nxt;
         r_irq  <= w_irq_nxt;
         r_vect <= w_vect_nxt;
      end
   end

   assign hirq_o = r_hirq;
   assign irq_o  = r_irq;
   assign vect_o = r_vect;
   assign busy   = r_busy;

endmodule

// File: tb/tb_qupls_irq_inject.sv
// Scoreboard bench for qupls_irq_inject: each stimulus cycle queues its expected outputs, a monitor compares them.
module tb_qupls_irq_inject;

`ifdef QUPLS_IRQ_TIMEOUT_EN
   localparam int unsigned TB_TMO = 4;
`else
   localparam int unsigned TB_TMO = 255;
`endif

   typedef struct {
      string      name;
      logic       chk;
      logic       hirq;
      logic [2:0] irq;
      logic [7:0] vect;
      logic       busy;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   exp_t exp_q[$];

   qupls_irq_inject_if bus ();

   qupls_irq_inject #(
      .TIMEOUT (TB_TMO)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .irq_i  (bus.irq),
      .vect_i (bus.vect),
      .im     (bus.im),
      .en     (bus.en),
      .flush  (bus.flush),
      .ack_i  (bus.ack),
      .hirq_o (bus.hirq),
      .irq_o  (bus.irq_lat),
      .vect_o (bus.vect_lat),
      .busy   (bus.busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: 2 time units after each rising edge, compare against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               n_checks++;
               if ({bus.hirq, bus.irq_lat, bus.vect_lat, bus.busy} !== {e.hirq, e.irq, e.vect, e.busy}) begin
                  n_errors++;
                  $display("FAIL %s: got hirq=%0b irq=%0d vect=%02h busy=%0b, want hirq=%0b irq=%0d vect=%02h busy=%0b",
                           e.name, bus.hirq, bus.irq_lat, bus.vect_lat, bus.busy,
                           e.hirq, e.irq, e.vect, e.busy);
               end
            end
         end
      end
   end

   // One clock of stimulus plus the outputs expected right after that edge.
   task automatic step(input string nm, input logic r, input logic [2:0] irq, input logic [7:0] vect,
                       input logic [2:0] im_v, input logic e, input logic f, input logic a,
                       input logic xh, input logic [2:0] xi, input logic [7:0] xv, input logic xb);
      exp_t x;
      @(negedge clk);
      rst       = r;
      bus.irq   = irq;
      bus.vect  = vect;
      bus.im    = im_v;
      bus.en    = e;
      bus.flush = f;
      bus.ack   = a;
      x.name = nm; x.chk = 1'b1; x.hirq = xh; x.irq = xi; x.vect = xv; x.busy = xb;
      exp_q.push_back(x);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.irq = 3'd0; bus.vect = 8'h00; bus.im = 3'd0;
      bus.en = 1'b0; bus.flush = 1'b0; bus.ack = 1'b0;

      //    name            rst   irq   vect   im    en    fl    ack   hirq  irq   vect   busy
      step("reset0",       1'b1, 3'd5, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
      step("reset1",       1'b1, 3'd0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

      step("capture",      1'b0, 3'd5, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h40, 1'b1);
      step("consume",      1'b0, 3'd5, 8'h40, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 8'h40, 1'b1);
      step("inflight",     1'b0, 3'd5, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h40, 1'b1);
      step("ack_idle",     1'b0, 3'd5, 8'h40, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 8'h40, 1'b0);
      step("recapture",    1'b0, 3'd5, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h40, 1'b1);
      step("withdraw",     1'b0, 3'd0, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h40, 1'b0);

      for (int i = 0; i < 20; i++) begin
         step("masked",    1'b0, 3'd5, 8'h33, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h40, 1'b0);
      end
      step("unmask",       1'b0, 3'd5, 8'h33, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h33, 1'b1);
      step("unmask_off",   1'b0, 3'd0, 8'h33, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h33, 1'b0);

      step("pre_cap",      1'b0, 3'd3, 8'h07, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h07, 1'b1);
      step("preempt",      1'b0, 3'd6, 8'h12, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 8'h12, 1'b1);
      step("pre_drop",     1'b0, 3'd0, 8'h12, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 8'h12, 1'b0);
      step("pre_cap2",     1'b0, 3'd3, 8'h07, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h07, 1'b1);
      step("present_ign",  1'b0, 3'd3, 8'h07, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h07, 1'b1);
      step("pre_en_wins",  1'b0, 3'd6, 8'h12, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 8'h07, 1'b1);
      step("inflt_hold",   1'b0, 3'd6, 8'h12, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'h07, 1'b1);

      step("flush",        1'b0, 3'd3, 8'h07, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 8'h07, 1'b1);
      step("flush_recons", 1'b0, 3'd3, 8'h07, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 8'h07, 1'b1);
      step("flush_ack",    1'b0, 3'd0, 8'h07, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 8'h07, 1'b0);
      step("idle_quiet",   1'b0, 3'd0, 8'h07, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'h07, 1'b0);

      step("rst_cap",      1'b0, 3'd5, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h40, 1'b1);
      step("rst_present",  1'b1, 3'd5, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
      step("rst_cap2",     1'b0, 3'd5, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h40, 1'b1);
      step("rst_cons",     1'b0, 3'd5, 8'h40, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 8'h40, 1'b1);
      step("rst_inflight", 1'b1, 3'd5, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

      step("tmo_cap",      1'b0, 3'd5, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h40, 1'b1);
      step("tmo_cons",     1'b0, 3'd0, 8'h40, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 8'h40, 1'b1);
`ifdef QUPLS_IRQ_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         step("tmo_wait",  1'b0, 3'd0, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h40, 1'b1);
      end
      step("tmo_repres",   1'b0, 3'd0, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h40, 1'b1);
`else
      for (int i = 0; i < 100; i++) begin
         step("no_tmo",    1'b0, 3'd0, 8'h40, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h40, 1'b1);
      end
`endif
      step("tmo_end",      1'b0, 3'd0, 8'h40, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 8'h40, 1'b0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #4;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
